// File: rtl/sdf_pkg.sv
// rtl/sdf_pkg.sv - shared state encoding and width helper for the R2SDF stage sequencer
package sdf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BFLY  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_tw_gen.sv
// rtl/sdf_tw_gen.sv - registered twiddle ROM address generator, updated once per stage step
module sdf_tw_gen import sdf_pkg::*; #(
  parameter int LOG2D     = 5,
  parameter int TW_STRIDE = 1,
  parameter int TW_AW     = 5
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             step_i,
  input  logic [LOG2D:0]   cnt_i,
  output logic [TW_AW-1:0] tw_addr_o
);

  logic [TW_AW-1:0] tw_addr_q;
  logic [TW_AW-1:0] tw_addr_d;
  logic [LOG2D-1:0] cnt_lo;
  logic             phase;

  // In the butterfly half the low counter bits are exactly cnt - D.
  assign cnt_lo = cnt_i[LOG2D-1:0];
  assign phase  = cnt_i[LOG2D];

  always_comb begin
    tw_addr_d = '0;
    if (phase) tw_addr_d = TW_AW'(32'(cnt_lo) * TW_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      tw_addr_q <= '0;
    end else if (step_i) begin
      tw_addr_q <= tw_addr_d;
    end
  end

  assign tw_addr_o = tw_addr_q;

endmodule

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - R2SDF FFT stage sequencer: delay FIFO enables, butterfly select, flush
// Optional sticky protocol/FIFO error output enabled by defining SDF_ERR_CHECK_EN.
module sdf_stage_ctrl import sdf_pkg::*; #(
  parameter int DEPTH     = 32,
  parameter int TW_STRIDE = 1,
  parameter int TW_AW     = 5
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             en_wr,
  output logic             en_rd,
  output logic             bf_sel,
  output logic             zero_in,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_valid,
  output logic             busy
`ifdef SDF_ERR_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int LOG2D = clog2(DEPTH);
  localparam int CW    = LOG2D + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          out_valid_q;
  logic          in_v;
  logic          step;
  logic          last_ok;

  // Reset blocks all FIFO activity in the cycle it is asserted.
  assign in_v    = in_valid && !areset;
  assign step    = !areset && (in_valid || (state_q == ST_FLUSH));
  assign last_ok = in_v && in_last && (state_q == ST_BFLY) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_valid_q <= en_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (step) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          cnt_d   = CW'(1);
          first_d = 1'b1;
        end
        ST_FILL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_HALF) state_d = ST_BFLY;
        end
        ST_BFLY: begin
          if (last_ok) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_FILL;
              first_d = 1'b0;
            end
          end
        end
        default: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_HALF) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // The FIFO is empty during the first frame, so its head is only read once a frame has been stored.
  always_comb begin
    en_wr   = 1'b0;
    en_rd   = 1'b0;
    bf_sel  = 1'b0;
    zero_in = 1'b0;
    case (state_q)
      ST_IDLE: en_wr = in_v;
      ST_FILL: begin
        en_wr = in_v;
        en_rd = in_v && !first_q;
      end
      ST_BFLY: begin
        en_wr  = in_v;
        en_rd  = in_v;
        bf_sel = 1'b1;
      end
      default: begin
        en_rd   = !areset;
        zero_in = 1'b1;
      end
    endcase
  end

  sdf_tw_gen #(
    .LOG2D     (LOG2D),
    .TW_STRIDE (TW_STRIDE),
    .TW_AW     (TW_AW)
  ) u_tw_gen (
    .clk       (clk),
    .areset    (areset),
    .step_i    (step),
    .cnt_i     (cnt_q),
    .tw_addr_o (tw_addr)
  );

  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SDF_ERR_CHECK_EN
  logic err_q;
  logic misplaced_last;

  assign misplaced_last = in_v && in_last && (state_q != ST_FLUSH) && !last_ok;

  always_ff @(posedge clk) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if ((en_wr && fifo_full && !en_rd) || (en_rd && fifo_empty) || misplaced_last) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_fifo_flags;
  assign unused_fifo_flags = fifo_full ^ fifo_empty;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - scoreboard bench for sdf_stage_ctrl with DEPTH=4 and a delay FIFO occupancy model
module tb_sdf_stage_ctrl;

  localparam int DEPTH     = 4;
  localparam int TW_STRIDE = 1;
  localparam int TW_AW     = 3;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             fifo_full;
  logic             fifo_empty;
  logic             en_wr, en_rd, bf_sel, zero_in, out_valid, busy;
  logic [TW_AW-1:0] tw_addr;
`ifdef SDF_ERR_CHECK_EN
  logic             err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int sb_q[$];
  int occ = 0;
  logic wr_s = 1'b0, rd_s = 1'b0, rst_s = 1'b1;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(
    .DEPTH     (DEPTH),
    .TW_STRIDE (TW_STRIDE),
    .TW_AW     (TW_AW)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .en_wr      (en_wr),
    .en_rd      (en_rd),
    .bf_sel     (bf_sel),
    .zero_in    (zero_in),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .busy       (busy)
`ifdef SDF_ERR_CHECK_EN
    ,
    .err        (err)
`endif
  );

  assign fifo_full  = (occ == DEPTH);
  assign fifo_empty = (occ == 0);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected twiddle address per output beat, and checks FIFO legality.
  always @(negedge clk) begin
    wr_s  = en_wr;
    rd_s  = en_rd;
    rst_s = areset;
    if (en_rd) chk("fifo_rd_not_empty", int'(fifo_empty), 0);
    if (en_wr && !en_rd) chk("fifo_wr_not_full", int'(fifo_full), 0);
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("tw_addr", int'(tw_addr), sb_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rst_s) occ <= 0;
    else occ <= occ + int'(wr_s) - int'(rd_s);
  end

  // exp_ctl = {busy, en_wr, en_rd, bf_sel, zero_in}
  task automatic step(input logic iv, input logic il, input logic [4:0] exp_ctl,
                      input logic push, input int tw);
    @(posedge clk);
    #1;
    in_valid = iv;
    in_last  = il;
    #1;
    chk("ctl", int'({busy, en_wr, en_rd, bf_sel, zero_in}), int'(exp_ctl));
    if (push) sb_q.push_back(tw);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    areset   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_ctl", int'({busy, en_wr, en_rd, bf_sel, zero_in}), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_tw_addr", int'(tw_addr), 0);
`ifdef SDF_ERR_CHECK_EN
    chk("rst_err", int'(err), 0);
`endif
    areset = 1'b0;
  endtask

  // First frame after IDLE: samples 0..n-1, in_last on sample last_at (-1 for none).
  task automatic first_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      if (i == 0)      step(1'b1, i == last_at, 5'b01000, 1'b0, 0);
      else if (i < 4)  step(1'b1, i == last_at, 5'b11000, 1'b0, 0);
      else             step(1'b1, i == last_at, 5'b11110, 1'b1, i - 4);
    end
  endtask

  initial begin
    do_reset();

    // Single gapless frame
    first_frame(8, -1);
    step(1'b0, 1'b0, 5'b10000, 1'b0, 0);

    // Two back-to-back frames: second FILL reads the stored half
    do_reset();
    first_frame(8, -1);
    for (int i = 8; i < 12; i++) step(1'b1, 1'b0, 5'b11100, 1'b1, 0);
    for (int i = 12; i < 16; i++) step(1'b1, 1'b0, 5'b11110, 1'b1, i - 12);
    step(1'b0, 1'b0, 5'b10000, 1'b0, 0);

    // Gaps during BFLY: addresses still 0,1,2,3
    do_reset();
    first_frame(4, -1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 5'b11110, 1'b1, k);
      if (k < 3) step(1'b0, 1'b0, 5'b10010, 1'b0, 0);
    end

    // Last sample ends the frame and starts a D-cycle flush
    do_reset();
    first_frame(8, 7);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5'b10101, 1'b1, 0);
    step(1'b0, 1'b0, 5'b00000, 1'b0, 0);
`ifdef SDF_ERR_CHECK_EN
    chk("err_clean_flush", int'(err), 0);
`endif

    // Reset mid-BFLY at cnt=6, then a fresh frame
    do_reset();
    first_frame(6, -1);
    do_reset();
    first_frame(8, -1);

    // Misplaced in_last at cnt=3 is ignored
    do_reset();
    first_frame(3, -1);
`ifdef SDF_ERR_CHECK_EN
    chk("err_before", int'(err), 0);
`endif
    step(1'b1, 1'b1, 5'b11000, 1'b0, 0);
    for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 5'b11110, 1'b1, i - 4);
    step(1'b0, 1'b0, 5'b10000, 1'b0, 0);
`ifdef SDF_ERR_CHECK_EN
    chk("err_sticky", int'(err), 1);
`endif
    do_reset();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencer for one radix-2 single-path delay-feedback (R2SDF) FFT stage.
- Drives the write/read enables of the stage's paired re/im delay FIFO (first-word-fall-through, depth DEPTH).
- Drives the butterfly routing mux select and the twiddle ROM address.
- Flushes the delay line after the last frame so the final frame's second-half outputs emerge.

Parameters:
- DEPTH, 32, stage delay D in samples; power of 2, >=2; equals the delay FIFO depth.
- TW_STRIDE, 1, twiddle address increment per sample (1 for first stage, doubles per later stage).
- TW_AW, 5, twiddle address width; must satisfy 2^TW_AW >= DEPTH*TW_STRIDE.

Ports:
- clk, in, 1, stage clock.
- areset, in, 1, reset; synchronous, active-high.
- in_valid, in, 1, input sample present this cycle.
- in_last, in, 1, qualifies final sample of final frame (valid only with in_valid).
- fifo_full, in, 1, OR of delay FIFO re/im full.
- fifo_empty, in, 1, OR of delay FIFO re/im empty.
- en_wr, out, 1, delay FIFO write enable.
- en_rd, out, 1, delay FIFO read enable.
- bf_sel, out, 1, 0 = route input into FIFO and FIFO head to output; 1 = butterfly (sum to output, difference into FIFO).
- zero_in, out, 1, force butterfly input operand to zero (flush).
- tw_addr, out, TW_AW, twiddle ROM address for the current FIFO head output.
- out_valid, out, 1, stage output valid; registered, one cycle after the driving step.
- busy, out, 1, state != IDLE.

Behaviour:
- Counter cnt, log2(DEPTH)+1 bits, counts steps modulo 2*DEPTH; phase = cnt MSB.
- A step is in_valid=1 in FILL/BFLY, or every cycle in FLUSH.
- States and transitions:
  - IDLE: in_valid -> FILL; cnt=1 after the step.
  - FILL (phase 0): en_wr=in_valid, en_rd=in_valid once the FIFO holds data from the previous frame, bf_sel=0.
    - First frame after IDLE: en_rd=0 and out_valid=0, because the FIFO is empty.
  - BFLY (phase 1): en_wr=en_rd=in_valid, bf_sel=1, out_valid follows in_valid.
  - cnt wrap 2D-1 -> 0: BFLY -> FILL; FILL at D-1 -> BFLY.
  - in_last in BFLY at cnt=2D-1 -> FLUSH, cnt=0.
  - in_last at any other cnt is a protocol error: stay in the current state, ignore in_last.
  - FLUSH: D cycles with en_rd=1, en_wr=0, bf_sel=0, zero_in=1, out_valid=1 (next cycle); then -> IDLE.
- en_wr, en_rd, bf_sel and zero_in are combinational from registered state/cnt and in_valid, so the FIFO acts in the same cycle.
- tw_addr:
  - Registered; 0 in FILL and FLUSH.
  - In BFLY = (cnt - D)*TW_STRIDE, truncated to TW_AW bits.
  - Aligned with out_valid.
- in_valid gaps: all state, cnt and tw_addr hold; en_wr=en_rd=0.
- Simultaneous in_valid at FLUSH end: sample dropped; the upstream contract is no input while busy in FLUSH.
- Reset (any state, including mid-frame or mid-FLUSH) at the next edge:
  - state=IDLE, cnt=0, tw_addr=0.
  - out_valid=0, busy=0; en_wr=en_rd=bf_sel=zero_in=0.
  - The FIFO is reset by the same areset.

Optional Feature:
- SDF_ERR_CHECK_EN defined:
  - Adds output err (1 bit), sticky until reset.
  - Sets when en_wr && fifo_full && !en_rd, when en_rd && fifo_empty, or on misplaced in_last.
- Undefined: no err port, no checking logic.

Decomposition:
- Shared package sdf_pkg:
  - State encoding constants ST_IDLE, ST_FILL, ST_BFLY, ST_FLUSH (2-bit).
  - Function clog2 for counter widths.
- One natural sub-module: sdf_tw_gen (registered twiddle address generator from cnt/phase/stride).

Test Plan:
- Reset, then DEPTH=4, 8 consecutive valids -> cycles 0-3 en_wr=1, en_rd=0, bf_sel=0; cycles 4-7 en_wr=en_rd=bf_sel=1, out_valid high cycles 5-8, tw_addr 0,1,2,3.
- Two back-to-back frames (16 valids) -> second FILL has en_rd=1 and out_valid=1; FIFO never full or empty on read.
- in_valid toggled 1/0 during BFLY -> cnt and tw_addr hold on 0 cycles; same address sequence as the gapless case.
- in_last on sample 8 -> 4 FLUSH cycles with en_rd=1, zero_in=1; then busy=0, state IDLE.
- areset asserted at BFLY cnt=6 -> next cycle all outputs 0, busy=0; a fresh frame restarts at FILL, cnt=0.
- SDF_ERR_CHECK_EN with in_last at cnt=3 -> err=1 stays until reset; sequence continues unchanged.
